// File: rtl/multicycle_controller.sv
// Five-state multicycle CPU control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Optional MEMORY wait timeout is enabled by defining MEM_TIMEOUT_EN.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       pc_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       alu_op,
    output logic       sel_A,
    output logic       sel_B,
    output logic       pc_sel,
    output logic [1:0] wb_sel,
    output logic       cs,
    output logic       wr,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] dbg_state
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t     r_state;
    logic [6:0] r_opcode;

    logic w_legal;
    logic w_is_i, w_is_load, w_is_store, w_is_branch, w_is_jal, w_is_jalr;
    logic w_timeout;

    // Legality is judged on the live opcode in DECODE; later states use the latched copy.
    assign w_legal = (opcode == OP_R)      || (opcode == OP_I)      ||
                     (opcode == OP_LOAD)   || (opcode == OP_STORE)  ||
                     (opcode == OP_BRANCH) || (opcode == OP_JAL)    ||
                     (opcode == OP_JALR);

    assign w_is_i      = (r_opcode == OP_I);
    assign w_is_load   = (r_opcode == OP_LOAD);
    assign w_is_store  = (r_opcode == OP_STORE);
    assign w_is_branch = (r_opcode == OP_BRANCH);
    assign w_is_jal    = (r_opcode == OP_JAL);
    assign w_is_jalr   = (r_opcode == OP_JALR);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] r_wait_cnt;

    // Fires on the TIMEOUT_CYCLES-th not-ready MEMORY cycle; mem_ready in that cycle wins.
    assign w_timeout = (r_state == S_MEMORY) && !mem_ready &&
                       (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_MEMORY) && !mem_ready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_opcode <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    r_opcode <= opcode;
                    r_state  <= w_legal ? S_EXECUTE : S_FETCH;
                end
                S_EXECUTE: begin
                    if (w_is_load || w_is_store) begin
                        r_state <= S_MEMORY;
                    end else if (w_is_branch) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    if (mem_ready) begin
                        r_state <= w_is_load ? S_WRITEBACK : S_FETCH;
                    end else if (w_timeout) begin
                        r_state <= S_FETCH;
                    end
                end
                S_WRITEBACK: r_state <= S_FETCH;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    assign dbg_state = r_state;

    // Outputs decode from state; reset overrides them in the same cycle.
    always_comb begin
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        reg_wr  = 1'b0;
        alu_op  = 1'b0;
        sel_A   = 1'b0;
        sel_B   = 1'b0;
        pc_sel  = 1'b0;
        wb_sel  = 2'b00;
        cs      = 1'b1;
        wr      = 1'b0;
        illegal = 1'b0;
        mem_err = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: ir_wr = 1'b1;
                S_DECODE: begin
                    if (!w_legal) begin
                        illegal = 1'b1;
                        pc_wr   = 1'b1;
                    end
                end
                S_EXECUTE: begin
                    alu_op = 1'b1;
                    sel_B  = w_is_i || w_is_load || w_is_store || w_is_jalr;
                    sel_A  = w_is_branch || w_is_jal;
                    if (w_is_branch) begin
                        pc_wr  = 1'b1;
                        pc_sel = br_taken;
                    end
                end
                S_MEMORY: begin
                    cs = 1'b0;
                    wr = w_is_store;
                    if (mem_ready) begin
                        pc_wr = w_is_store;
                    end else if (w_timeout) begin
                        mem_err = 1'b1;
                        pc_wr   = 1'b1;
                    end
                end
                S_WRITEBACK: begin
                    reg_wr = 1'b1;
                    pc_wr  = 1'b1;
                    if (w_is_load) begin
                        wb_sel = 2'b01;
                    end else if (w_is_jal || w_is_jalr) begin
                        wb_sel = 2'b10;
                        pc_sel = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected output vectors
// queued by the driver, compared by a negedge monitor. Define MEM_TIMEOUT_EN for timeout cases.
module tb_multicycle_controller;

    localparam int TIMEOUT = 15;
    localparam int W = 16;

    localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4;
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;

    // ctl = {pc_wr, ir_wr, reg_wr, alu_op, sel_A, sel_B, pc_sel}; mem = {cs, wr, illegal, mem_err}
    localparam logic [6:0] C_NONE = 7'b0000000, C_FETCH = 7'b0100000, C_PCWR = 7'b1000000;
    localparam logic [6:0] C_EX_R = 7'b0001000, C_EX_B = 7'b0001010, C_EX_A = 7'b0001100;
    localparam logic [6:0] C_WB = 7'b1010000, C_WB_J = 7'b1010001;
    localparam logic [3:0] M_IDLE = 4'b1000, M_RD = 4'b0000, M_WR = 4'b0100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic       br_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_wr, ir_wr, reg_wr, alu_op, sel_A, sel_B, pc_sel;
    logic [1:0] wb_sel;
    logic       cs, wr, illegal, mem_err;
    logic [2:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    multicycle_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .br_taken(br_taken),
        .mem_ready(mem_ready), .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr),
        .alu_op(alu_op), .sel_A(sel_A), .sel_B(sel_B), .pc_sel(pc_sel),
        .wb_sel(wb_sel), .cs(cs), .wr(wr), .illegal(illegal), .mem_err(mem_err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [6:0] ctl,
                                        input logic [1:0] wb, input logic [3:0] mem);
        return {st, ctl, wb, mem};
    endfunction

    // One clock per call: inputs applied just after the edge, expectation queued for this cycle.
    task automatic step(input logic rst, input logic [6:0] op, input logic br,
                        input logic mr, input logic [W-1:0] e);
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = op;
        br_taken  = br;
        mem_ready = mr;
        exp_q.push_back(e);
    endtask

    task automatic fetch_decode(input logic [6:0] op);
        step(1'b0, op, 1'b0, 1'b0, ev(SF, C_FETCH, 2'b00, M_IDLE));
        step(1'b0, op, 1'b0, 1'b0, ev(SD, C_NONE, 2'b00, M_IDLE));
    endtask

    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        got = {dbg_state, pc_wr, ir_wr, reg_wr, alu_op, sel_A, sel_B, pc_sel,
               wb_sel, cs, wr, illegal, mem_err};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t got st=%0d ctl=%b wb=%b mem=%b exp st=%0d ctl=%b wb=%b mem=%b",
                         $time, got[15:13], got[12:6], got[5:4], got[3:0],
                         e[15:13], e[12:6], e[5:4], e[3:0]);
            end
            n_checks++;
            if (reg_wr === 1'b1 && wr === 1'b1) begin
                n_errors++;
                $display("FAIL regwr_wr_overlap t=%0t got reg_wr=1 wr=1 exp not both", $time);
            end
        end
    end

    initial begin
        // Reset held two cycles: outputs idle, state parked in FETCH.
        step(1'b1, OP_R, 1'b0, 1'b0, ev(SF, C_NONE, 2'b00, M_IDLE));
        step(1'b1, OP_R, 1'b0, 1'b0, ev(SF, C_NONE, 2'b00, M_IDLE));

        // R-type
        fetch_decode(OP_R);
        step(1'b0, OP_R, 1'b0, 1'b0, ev(SE, C_EX_R, 2'b00, M_IDLE));
        step(1'b0, OP_R, 1'b0, 1'b0, ev(SW, C_WB, 2'b00, M_IDLE));
        // I-type
        fetch_decode(OP_I);
        step(1'b0, OP_I, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        step(1'b0, OP_I, 1'b0, 1'b0, ev(SW, C_WB, 2'b00, M_IDLE));
        // JAL
        fetch_decode(OP_JAL);
        step(1'b0, OP_JAL, 1'b0, 1'b0, ev(SE, C_EX_A, 2'b00, M_IDLE));
        step(1'b0, OP_JAL, 1'b0, 1'b0, ev(SW, C_WB_J, 2'b10, M_IDLE));
        // JALR
        fetch_decode(OP_JALR);
        step(1'b0, OP_JALR, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        step(1'b0, OP_JALR, 1'b0, 1'b0, ev(SW, C_WB_J, 2'b10, M_IDLE));
        // Branch taken / not taken
        fetch_decode(OP_BR);
        step(1'b0, OP_BR, 1'b1, 1'b0, ev(SE, 7'b1001101, 2'b00, M_IDLE));
        fetch_decode(OP_BR);
        step(1'b0, OP_BR, 1'b0, 1'b0, ev(SE, 7'b1001100, 2'b00, M_IDLE));
        // Load with three wait cycles
        fetch_decode(OP_LD);
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        for (int i = 0; i < 3; i++) step(1'b0, OP_LD, 1'b0, 1'b0, ev(SM, C_NONE, 2'b00, M_RD));
        step(1'b0, OP_LD, 1'b0, 1'b1, ev(SM, C_NONE, 2'b00, M_RD));
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SW, C_WB, 2'b01, M_IDLE));
        // Store with one wait cycle
        fetch_decode(OP_ST);
        step(1'b0, OP_ST, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        step(1'b0, OP_ST, 1'b0, 1'b0, ev(SM, C_NONE, 2'b00, M_WR));
        step(1'b0, OP_ST, 1'b0, 1'b1, ev(SM, C_PCWR, 2'b00, M_WR));
        // Illegal opcodes
        step(1'b0, 7'b0000000, 1'b0, 1'b0, ev(SF, C_FETCH, 2'b00, M_IDLE));
        step(1'b0, 7'b0000000, 1'b0, 1'b0, ev(SD, C_PCWR, 2'b00, 4'b1010));
        step(1'b0, 7'b1111111, 1'b0, 1'b0, ev(SF, C_FETCH, 2'b00, M_IDLE));
        step(1'b0, 7'b1111111, 1'b0, 1'b0, ev(SD, C_PCWR, 2'b00, 4'b1010));
        // Store abandoned by reset on its second MEMORY cycle (mem_ready high must not complete it)
        fetch_decode(OP_ST);
        step(1'b0, OP_ST, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        step(1'b0, OP_ST, 1'b0, 1'b0, ev(SM, C_NONE, 2'b00, M_WR));
        step(1'b1, OP_ST, 1'b0, 1'b1, ev(SM, C_NONE, 2'b00, M_IDLE));
        fetch_decode(OP_R);
        step(1'b0, OP_R, 1'b0, 1'b0, ev(SE, C_EX_R, 2'b00, M_IDLE));
        step(1'b0, OP_R, 1'b0, 1'b0, ev(SW, C_WB, 2'b00, M_IDLE));
`ifdef MEM_TIMEOUT_EN
        // Load never answered: error on the TIMEOUT-th MEMORY cycle, then FETCH
        fetch_decode(OP_LD);
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, OP_LD, 1'b0, 1'b0, ev(SM, C_NONE, 2'b00, M_RD));
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SM, C_PCWR, 2'b00, 4'b0001));
        // mem_ready arriving in the timeout cycle completes normally
        fetch_decode(OP_LD);
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SE, C_EX_B, 2'b00, M_IDLE));
        for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, OP_LD, 1'b0, 1'b0, ev(SM, C_NONE, 2'b00, M_RD));
        step(1'b0, OP_LD, 1'b0, 1'b1, ev(SM, C_NONE, 2'b00, M_RD));
        step(1'b0, OP_LD, 1'b0, 1'b0, ev(SW, C_WB, 2'b01, M_IDLE));
`endif
        step(1'b0, OP_R, 1'b0, 1'b0, ev(SF, C_FETCH, 2'b00, M_IDLE));

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, SHALL set the MEMORY-state wait limit used only when MEM_TIMEOUT_EN is defined; legal range 1..255.
REQ-002 clk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-003 reset  in  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 opcode  in  7  SHALL be the instruction opcode field, valid while ir_wr has been applied (from DECODE onward).
REQ-005 br_taken  in  1  SHALL be the branch comparator result, sampled in EXECUTE.
REQ-006 mem_ready  in  1  SHALL be the data memory completion handshake, sampled in MEMORY.
REQ-007 pc_wr, ir_wr, reg_wr, alu_op, sel_A, sel_B  out  1 each  SHALL be the PC enable, IR enable, register-file write, ALU enable, ALU A-select (1=PC), and ALU B-select (1=immediate).
REQ-008 pc_sel  out  1  SHALL select the next PC: 0=PC+4, 1=ALU result.
REQ-009 wb_sel  out  2  SHALL select write-back: 00=ALU, 01=memory, 10=PC+4.
REQ-010 cs  out  1  SHALL be the active-low data memory chip select; wr  out  1  SHALL be the memory write strobe (1=store).
REQ-011 illegal, mem_err  out  1 each  SHALL be one-cycle error pulses.

Function
REQ-012 The FSM SHALL have states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK; all outputs SHALL decode from the state register and the opcode latched in DECODE.
REQ-013 FETCH: ir_wr=1 for exactly one cycle, then DECODE.
REQ-014 DECODE: opcode latched; recognised opcodes (0110011 R, 0010011 I, 0000011 load, 0100011 store, 1100011 branch, 1101111 JAL, 1100111 JALR) go to EXECUTE; any other opcode pulses illegal=1 and pc_wr=1 with pc_sel=0, then FETCH.
REQ-015 EXECUTE: alu_op=1; sel_B=1 for I, load, store, JALR; sel_A=1 for branch and JAL; else 0.
REQ-016 EXECUTE next state: R, I, JAL, JALR go to WRITEBACK; load, store go to MEMORY; branch goes to FETCH with pc_wr=1 and pc_sel=br_taken.
REQ-017 MEMORY: cs=0; wr=1 for store, 0 for load; held every cycle until mem_ready=1.
REQ-018 On mem_ready=1 in MEMORY: load goes to WRITEBACK; store goes to FETCH with pc_wr=1, pc_sel=0.
REQ-019 WRITEBACK: reg_wr=1, pc_wr=1 for exactly one cycle; wb_sel=01 for load, 10 for JAL/JALR, 00 otherwise; pc_sel=1 for JAL/JALR, else 0; then FETCH.
REQ-020 Outside the listed cases every output SHALL be 0, except cs, which SHALL be 1.
REQ-021 reg_wr and wr SHALL never be 1 in the same cycle; reg_wr SHALL be 1 only in WRITEBACK.
REQ-022 Latency: R/I/JAL/JALR take 4 cycles, branch 3, load 5+W, store 4+W, where W is the number of mem_ready=0 cycles.

Reset
REQ-023 While reset=1, outputs SHALL be forced to 0 (cs=1) in that same cycle, and the next state SHALL be FETCH; any timeout counter SHALL clear.
REQ-024 Reset asserted in MEMORY SHALL abandon the access with no write-back and no pc_wr.

Configuration
REQ-025 With MEM_TIMEOUT_EN defined: a counter SHALL count MEMORY cycles with mem_ready=0.
REQ-026 With MEM_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES SHALL pulse mem_err=1 and pc_wr=1 with pc_sel=0, and go to FETCH without reg_wr.
REQ-027 With MEM_TIMEOUT_EN defined, mem_ready=1 in the timeout cycle SHALL win: normal completion and no mem_err.
REQ-028 Without MEM_TIMEOUT_EN, MEMORY SHALL wait indefinitely, mem_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-029 Reset for 2 cycles, then release with opcode 0110011 -> FETCH(ir_wr=1), DECODE, EXECUTE(alu_op=1, sel_B=0), WRITEBACK(reg_wr=1, wb_sel=00, pc_wr=1), back to FETCH at cycle 4.
REQ-030 Load, with mem_ready low for 3 cycles -> cs=0, wr=0 for 4 MEMORY cycles, then WRITEBACK with wb_sel=01; total 8 cycles.
REQ-031 Branch with br_taken=1 -> EXECUTE asserts sel_A=1, pc_wr=1, pc_sel=1, reg_wr=0; then FETCH.
REQ-032 Opcode 0000000 -> illegal=1 and pc_wr=1 in DECODE; next cycle FETCH; no reg_wr or cs=0 ever.
REQ-033 Store with reset asserted on the 2nd MEMORY cycle -> cs=1, wr=0 in the reset cycle; FETCH next; no pc_wr.
REQ-034 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=15, load with mem_ready held 0 -> mem_err=1 on the 15th MEMORY cycle, then FETCH, no reg_wr; repeat with mem_ready=1 on that cycle -> no mem_err, WRITEBACK.
